// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and decoder state type, used by both the VGA timing
// generator and the sync decoder.
package vga_timing_pkg;

  localparam int unsigned H_VISIBLE   = 640;
  localparam int unsigned H_FP        = 16;
  localparam int unsigned H_PW        = 96;
  localparam int unsigned H_BP        = 48;
  localparam int unsigned V_VISIBLE   = 480;
  localparam int unsigned V_FP        = 10;
  localparam int unsigned V_PW        = 2;
  localparam int unsigned V_BP        = 33;
  localparam int unsigned LOCK_FRAMES = 2;

  localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_PW + H_BP;
  localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_PW + V_BP;
  localparam int unsigned HS_START = H_VISIBLE + H_FP;
  localparam int unsigned VS_START = V_VISIBLE + V_FP;

  localparam logic [15:0] CRC_INIT = 16'hFFFF;
  localparam logic [15:0] CRC_POLY = 16'h1021;

  typedef enum logic [1:0] {
    HUNT,
    SYNC,
    LOCKED
  } dec_state_e;

endpackage

// File: rtl/vga_crc16.sv
// CRC-16/CCITT over one 12-bit pixel per cycle, MSB first, with seed/enable control.
// Only compiled when VGA_DEC_CRC_EN is defined.
`ifdef VGA_DEC_CRC_EN
module vga_crc16
  import vga_timing_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed,
  input  logic        en,
  input  logic [11:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_q;
  logic [15:0] base;
  logic [15:0] stepped;

  // Folding the word into the top bits then shifting 12 times equals 12 serial bit steps.
  always_comb begin
    base    = seed ? CRC_INIT : crc_q;
    stepped = base ^ {data, 4'b0000};
    for (int i = 0; i < 12; i++) begin
      stepped = stepped[15] ? ((stepped << 1) ^ CRC_POLY) : (stepped << 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_q <= CRC_INIT;
    end else if (en) begin
      crc_q <= stepped;
    end else if (seed) begin
      crc_q <= CRC_INIT;
    end
  end

  assign crc = crc_q;

endmodule
`endif

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates/colour from VGA sync + RGB and checks timing (HUNT/SYNC/LOCKED).
// Optional per-frame CRC-16 of visible pixels is built when VGA_DEC_CRC_EN is defined.
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE   = vga_timing_pkg::H_VISIBLE,
  parameter int unsigned H_FP        = vga_timing_pkg::H_FP,
  parameter int unsigned H_PW        = vga_timing_pkg::H_PW,
  parameter int unsigned H_BP        = vga_timing_pkg::H_BP,
  parameter int unsigned V_VISIBLE   = vga_timing_pkg::V_VISIBLE,
  parameter int unsigned V_FP        = vga_timing_pkg::V_FP,
  parameter int unsigned V_PW        = vga_timing_pkg::V_PW,
  parameter int unsigned V_BP        = vga_timing_pkg::V_BP,
  parameter int unsigned LOCK_FRAMES = vga_timing_pkg::LOCK_FRAMES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [11:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        err,
  output logic [15:0] frame_crc,
  output logic        frame_crc_valid
);
  import vga_timing_pkg::*;

  localparam logic [9:0] HLast   = 10'(H_VISIBLE + H_FP + H_PW + H_BP - 1);
  localparam logic [9:0] VLast   = 10'(V_VISIBLE + V_FP + V_PW + V_BP - 1);
  localparam logic [9:0] HsFirst = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HsLast  = 10'(H_VISIBLE + H_FP + H_PW - 1);
  localparam logic [9:0] VsFirst = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VsLast  = 10'(V_VISIBLE + V_FP + V_PW - 1);
  localparam logic [9:0] HVis    = 10'(H_VISIBLE);
  localparam logic [9:0] VVis    = 10'(V_VISIBLE);
  localparam logic [3:0] LockCnt = 4'(LOCK_FRAMES);

  logic        hs_q, vs_q, vs_prev_q;
  logic [11:0] rgb_q;
  dec_state_e  state_q, state_d;
  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [3:0]  frames_q, frames_d;
  logic        vs_fall, exp_h, exp_v, mismatch, matched_fall;
  logic        out_en, visible, pix_valid_d, frame_start_d;
  logic        pix_valid_q, frame_start_q, err_q;
  logic [9:0]  pix_x_q, pix_y_q;
  logic [11:0] pix_rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      rgb_q     <= '0;
    end else begin
      hs_q      <= hsync;
      vs_q      <= vsync;
      vs_prev_q <= vs_q;
      rgb_q     <= {red, green, blue};
    end
  end

  assign vs_fall      = vs_prev_q & ~vs_q;
  assign exp_h        = ~((h_q >= HsFirst) && (h_q <= HsLast));
  assign exp_v        = ~((v_q >= VsFirst) && (v_q <= VsLast));
  assign mismatch     = (state_q != HUNT) && ((hs_q != exp_h) || (vs_q != exp_v));
  assign matched_fall = !mismatch && vs_fall && (h_q == '0) && (v_q == VsFirst);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= HUNT;
      frames_q <= '0;
      h_q      <= '0;
      v_q      <= '0;
    end else begin
      state_q  <= state_d;
      frames_q <= frames_d;
      h_q      <= h_d;
      v_q      <= v_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    frames_d = frames_q;
    unique case (state_q)
      HUNT: begin
        if (vs_fall) begin
          state_d  = SYNC;
          frames_d = '0;
        end
      end
      SYNC: begin
        if (mismatch) begin
          state_d = HUNT;
        end else if (matched_fall) begin
          frames_d = frames_q + 4'd1;
          if (frames_q + 4'd1 == LockCnt) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (mismatch) state_d = HUNT;
      end
      default: state_d = HUNT;
    endcase
  end

  // In HUNT the counters only move when a vsync fall pins the sample to (0, VsFirst).
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (state_q == HUNT) begin
      if (vs_fall) begin
        h_d = 10'd1;
        v_d = VsFirst;
      end
    end else if (h_q == HLast) begin
      h_d = '0;
      v_d = (v_q == VLast) ? '0 : v_q + 10'd1;
    end else begin
      h_d = h_q + 10'd1;
    end
  end

  always_comb begin
    out_en        = (state_q == LOCKED) && !mismatch;
    visible       = (h_q < HVis) && (v_q < VVis);
    pix_valid_d   = out_en && visible;
    frame_start_d = out_en && (h_q == '0) && (v_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      err_q         <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      pix_rgb_q     <= '0;
    end else begin
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      err_q         <= mismatch;
      if (out_en) begin
        pix_x_q   <= h_q;
        pix_y_q   <= v_q;
        pix_rgb_q <= rgb_q;
      end
    end
  end

  assign pix_valid   = pix_valid_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign pix_rgb     = pix_rgb_q;
  assign frame_start = frame_start_q;
  assign err         = err_q;
  assign locked      = (state_q == LOCKED);

`ifdef VGA_DEC_CRC_EN
  logic [15:0] crc_run;
  logic        crc_seed, crc_en, frame_end;
  logic [15:0] frame_crc_q;
  logic        frame_crc_valid_q;

  // Reseeding whenever not outputting discards any partial CRC on loss of lock.
  assign crc_seed  = !out_en || ((h_q == '0) && (v_q == '0));
  assign crc_en    = out_en && visible;
  assign frame_end = out_en && (h_q == '0) && (v_q == VVis);

  vga_crc16 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (crc_seed),
    .en    (crc_en),
    .data  (rgb_q),
    .crc   (crc_run)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_crc_q       <= '0;
      frame_crc_valid_q <= 1'b0;
    end else begin
      frame_crc_valid_q <= frame_end;
      if (frame_end) frame_crc_q <= crc_run;
    end
  end

  assign frame_crc       = frame_crc_q;
  assign frame_crc_valid = frame_crc_valid_q;
`else
  assign frame_crc       = '0;
  assign frame_crc_valid = 1'b0;
`endif

endmodule
